// File: rtl/snake_dir_ctrl.sv
// snake_dir_ctrl
// Turns the four raw active-low push buttons into a registered snake heading
// for the game FSM. Each key is synchronised (2 flops), debounced, and
// edge-detected into a one-cycle press event. Press events pass a legality
// filter (no duplicate, no 180 degree reversal) and go into a small circular
// queue of pending turns; the game FSM pops one turn per step pulse.
//
// Ports:
//   clk          system clock
//   rst_n        asynchronous active-low reset
//   key_n[3:0]   raw buttons, active low, {LEFT,UP,DOWN,RIGHT}
//   step         one-cycle pulse: snake advances, consume one pending turn
//   clear        synchronous restart (keeps the key synchronisers)
//   dir[1:0]     current heading: 00 RIGHT, 01 LEFT, 10 UP, 11 DOWN
//   pending[2:0] number of queued turns, 0..DEPTH
//   dir_changed  one-cycle pulse when dir takes a new value
//   press_drop   one-cycle pulse when a detected press is discarded
//
// Handshake: there is no backpressure. step is a single-cycle strobe sampled
// on every rising edge; the turn it consumes is visible on dir after that
// edge, together with the dir_changed pulse.
module snake_dir_ctrl #(
    parameter int unsigned DEBOUNCE_CYCLES = 500000,
    parameter int unsigned DEPTH           = 2,
    parameter logic [1:0]  INIT_DIR        = 2'b00
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] key_n,
    input  logic       step,
    input  logic       clear,
    output logic [1:0] dir,
    output logic [2:0] pending,
    output logic       dir_changed,
    output logic       press_drop
);

    // Counter runs 0..DEBOUNCE_CYCLES-1; the level flips on the cycle that
    // would make it reach DEBOUNCE_CYCLES.
    localparam int unsigned   CW       = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);
    localparam logic [2:0]    DEPTH_L  = 3'(DEPTH);
    localparam logic [1:0]    PTR_LAST = 2'(DEPTH - 1);

    logic [3:0]    r_sync1;
    logic [3:0]    r_sync2;
    logic [3:0]    r_deb;      // debounced level, active high
    logic [3:0]    r_deb_d;    // previous debounced level for edge detection
    logic [3:0]    r_press;    // registered press events
    logic [CW-1:0] r_cnt [4];

    logic [1:0]    r_q [4];
    logic [1:0]    r_rd;
    logic [1:0]    r_wr;
    logic [2:0]    r_count;
    logic [1:0]    r_dir;
    logic          r_dir_changed;
    logic          r_press_drop;

    logic [3:0]    w_lvl;
    logic [1:0]    w_tail;
    logic [1:0]    w_ref;
    logic [1:0]    w_cand;
    logic          w_cand_ok;
    logic [1:0]    w_code;
    logic          w_legal;
    logic          w_any_ev;
    logic          w_room;
    logic          w_push;
    logic          w_pop;
    logic          w_drop;

    function automatic logic [1:0] key_code(input int idx);
        case (idx)
            3:       return 2'b01;  // LEFT
            2:       return 2'b10;  // UP
            1:       return 2'b11;  // DOWN
            default: return 2'b00;  // RIGHT
        endcase
    endfunction

    function automatic logic [1:0] ptr_next(input logic [1:0] p);
        return (p == PTR_LAST) ? 2'd0 : p + 2'd1;
    endfunction

    // Synchronisers hold the raw active-low value; clear leaves them alone.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync1 <= 4'hF;
            r_sync2 <= 4'hF;
        end else begin
            r_sync1 <= key_n;
            r_sync2 <= r_sync1;
        end
    end

    assign w_lvl = ~r_sync2;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_deb   <= '0;
            r_deb_d <= '0;
            r_press <= '0;
            for (int i = 0; i < 4; i++) r_cnt[i] <= '0;
        end else if (clear) begin
            r_deb   <= '0;
            r_deb_d <= '0;
            r_press <= '0;
            for (int i = 0; i < 4; i++) r_cnt[i] <= '0;
        end else begin
            r_deb_d <= r_deb;
            r_press <= r_deb & ~r_deb_d;
            for (int i = 0; i < 4; i++) begin
                if (w_lvl[i] == r_deb[i]) begin
                    r_cnt[i] <= '0;
                end else if (r_cnt[i] == CNT_LAST) begin
                    r_cnt[i] <= '0;
                    r_deb[i] <= w_lvl[i];
                end else begin
                    r_cnt[i] <= r_cnt[i] + CW'(1);
                end
            end
        end
    end

    // New presses are judged against the last queued turn, or the live
    // heading when nothing is queued.
    assign w_tail = (r_wr == 2'd0) ? PTR_LAST : r_wr - 2'd1;
    assign w_ref  = (r_count != 3'd0) ? r_q[w_tail] : r_dir;

    // Among simultaneous presses the highest-priority legal one wins
    // (LEFT>UP>DOWN>RIGHT). If none is legal, the highest-priority press is
    // the one reported as dropped; the others vanish silently.
    always_comb begin
        w_cand    = 2'b00;
        w_cand_ok = 1'b0;
        w_code    = 2'b00;
        w_legal   = 1'b0;
        for (int i = 0; i < 4; i++) begin
            w_code  = key_code(i);
            w_legal = (w_code != w_ref) &&
                      !((w_code[1] == w_ref[1]) && (w_code[0] != w_ref[0]));
            if (r_press[i]) begin
                if (w_legal) begin
                    w_cand    = w_code;
                    w_cand_ok = 1'b1;
                end else if (!w_cand_ok) begin
                    w_cand = w_code;
                end
            end
        end
    end

    assign w_any_ev = |r_press;
    assign w_room   = (r_count < DEPTH_L) || step;
    assign w_push   = w_any_ev && w_cand_ok && w_room;
    assign w_drop   = w_any_ev && !w_push;
    assign w_pop    = step && (r_count != 3'd0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_dir         <= INIT_DIR;
            r_rd          <= '0;
            r_wr          <= '0;
            r_count       <= '0;
            r_dir_changed <= 1'b0;
            r_press_drop  <= 1'b0;
            for (int i = 0; i < 4; i++) r_q[i] <= '0;
        end else if (clear) begin
            r_dir         <= INIT_DIR;
            r_rd          <= '0;
            r_wr          <= '0;
            r_count       <= '0;
            r_dir_changed <= 1'b0;
            r_press_drop  <= 1'b0;
        end else begin
            r_dir_changed <= w_pop;
            r_press_drop  <= w_drop;
            // Pop reads the pre-edge head, so a same-edge push into a full
            // queue safely reuses the freed slot.
            if (w_pop) begin
                r_dir <= r_q[r_rd];
                r_rd  <= ptr_next(r_rd);
            end
            if (w_push) begin
                r_q[r_wr] <= w_cand;
                r_wr      <= ptr_next(r_wr);
            end
            r_count <= r_count + 3'(w_push) - 3'(w_pop);
        end
    end

    assign dir         = r_dir;
    assign pending     = r_count;
    assign dir_changed = r_dir_changed;
    assign press_drop  = r_press_drop;

endmodule

// File: tb/tb_snake_dir_ctrl.sv
// Bench for snake_dir_ctrl with a short debounce and a two-entry queue.
// A reference model follows the raw key levels with run lengths and keeps
// the pending turns in a queue; every cycle all four outputs are compared.
module tb_snake_dir_ctrl;

    localparam int         DB   = 4;
    localparam int         DP   = 2;
    localparam logic [1:0] INIT = 2'b00;

    localparam logic [1:0] D_RIGHT = 2'b00;
    localparam logic [1:0] D_LEFT  = 2'b01;
    localparam logic [1:0] D_UP    = 2'b10;
    localparam logic [1:0] D_DOWN  = 2'b11;

    localparam logic [3:0] K_NONE  = 4'b1111;
    localparam logic [3:0] K_LEFT  = 4'b0111;
    localparam logic [3:0] K_UP    = 4'b1011;
    localparam logic [3:0] K_DOWN  = 4'b1101;
    localparam logic [3:0] K_RIGHT = 4'b1110;

    // ---------------- clock / reset / DUT ----------------
    logic       clk = 1'b0;
    logic       rst_n;
    logic [3:0] key_n;
    logic       step;
    logic       clear;
    logic [1:0] dir;
    logic [2:0] pending;
    logic       dir_changed;
    logic       press_drop;

    always #5 clk = ~clk;

    snake_dir_ctrl #(
        .DEBOUNCE_CYCLES(DB),
        .DEPTH          (DP),
        .INIT_DIR       (INIT)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .key_n      (key_n),
        .step       (step),
        .clear      (clear),
        .dir        (dir),
        .pending    (pending),
        .dir_changed(dir_changed),
        .press_drop (press_drop)
    );

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout required completion");
        $fatal(1, "watchdog");
    end

    // ---------------- scoreboard ----------------
    int n_checks  = 0;
    int n_fail    = 0;
    int seen_drop = 0;
    int seen_chg  = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d required %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    int         e_cnt;
    bit         m_lvl [4];   // raw level, 1 = pressed
    int         m_run [4];   // edges the raw level has been stable
    bit         m_acc [4];   // accepted (debounced) level
    int         m_due [4];   // edge at which the press reaches the queue logic
    logic [1:0] m_dir;
    logic [1:0] m_q[$];
    logic       m_chg;
    logic       m_drop;

    function automatic logic [1:0] kdir(input int k);
        case (k)
            3:       return D_LEFT;
            2:       return D_UP;
            1:       return D_DOWN;
            default: return D_RIGHT;
        endcase
    endfunction

    task automatic m_reset();
        for (int k = 0; k < 4; k++) begin
            m_lvl[k] = 1'b0;
            m_run[k] = DB;
            m_acc[k] = 1'b0;
            m_due[k] = -1;
        end
        m_dir  = INIT;
        m_q.delete();
        m_chg  = 1'b0;
        m_drop = 1'b0;
    endtask

    task automatic model_edge(input logic [3:0] kn, input logic st, input logic cl);
        bit         p;
        bit         any;
        bit         found;
        bit         legal;
        bit         ok;
        int         k;
        logic [1:0] rf;
        logic [1:0] c;
        logic [1:0] cand;
        e_cnt++;
        // A level counts once it has been stable for DB edges; a press then
        // shows up four edges later (two sync stages, edge detect, decision).
        for (int i = 0; i < 4; i++) begin
            p = !kn[i];
            if (p == m_lvl[i]) begin
                if (m_run[i] < 1000) m_run[i]++;
            end else begin
                m_lvl[i] = p;
                m_run[i] = 1;
            end
            if (m_run[i] == DB && m_lvl[i] != m_acc[i]) begin
                m_acc[i] = m_lvl[i];
                if (p) m_due[i] = e_cnt + 4;
            end
        end
        m_chg  = 1'b0;
        m_drop = 1'b0;
        if (cl) begin
            m_dir = INIT;
            m_q.delete();
            // Held keys restart debouncing from the already-synchronised level.
            for (int i = 0; i < 4; i++) begin
                m_due[i] = -1;
                m_acc[i] = 1'b0;
                if (m_lvl[i] && m_run[i] > 2) m_run[i] = 2;
            end
            return;
        end
        rf    = (m_q.size() > 0) ? m_q[$] : m_dir;
        any   = 1'b0;
        found = 1'b0;
        cand  = 2'b00;
        for (int j = 0; j < 4; j++) begin
            k = 3 - j;  // LEFT, UP, DOWN, RIGHT
            if (m_due[k] == e_cnt) begin
                c     = kdir(k);
                legal = (c != rf) && !(c[1] == rf[1] && c[0] != rf[0]);
                if (!any) cand = c;
                if (legal && !found) begin
                    cand  = c;
                    found = 1'b1;
                end
                any = 1'b1;
            end
        end
        ok = any && found && ((m_q.size() < DP) || st);
        if (any && !ok) m_drop = 1'b1;
        if (st && m_q.size() > 0) begin
            m_dir = m_q.pop_front();
            m_chg = 1'b1;
        end
        if (ok) m_q.push_back(cand);
    endtask

    // ---------------- driver ----------------
    // Called at a falling edge; applies inputs for the next rising edge and
    // compares outputs at the following falling edge.
    task automatic tick(input logic [3:0] kn, input logic st, input logic cl);
        key_n = kn;
        step  = st;
        clear = cl;
        @(posedge clk);
        model_edge(kn, st, cl);
        @(negedge clk);
        chk("dir", int'(dir), int'(m_dir));
        chk("pending", int'(pending), m_q.size());
        chk("dir_changed", int'(dir_changed), int'(m_chg));
        chk("press_drop", int'(press_drop), int'(m_drop));
        if (press_drop) seen_drop++;
        if (dir_changed) seen_chg++;
    endtask

    // ---------------- vectors ----------------
    typedef struct {
        logic [3:0] key_n;
        logic       do_step;
        logic [1:0] exp_dir;
        int         exp_pend;
        int         exp_drops;
        int         exp_chg;
    } vec_t;

    localparam int NV = 12;
    vec_t vec [NV];

    logic [3:0] rk;
    int         rlen [4];

    initial begin
        vec[0]  = '{K_LEFT,  1'b0, D_RIGHT, 0, 1, 0};  // reversal of RIGHT
        vec[1]  = '{K_RIGHT, 1'b0, D_RIGHT, 0, 1, 0};  // duplicate
        vec[2]  = '{K_UP,    1'b0, D_RIGHT, 1, 0, 0};
        vec[3]  = '{K_NONE,  1'b1, D_UP,    0, 0, 1};
        vec[4]  = '{K_DOWN,  1'b0, D_UP,    0, 1, 0};  // reversal of UP
        vec[5]  = '{K_LEFT,  1'b1, D_LEFT,  0, 0, 1};
        vec[6]  = '{K_UP,    1'b0, D_LEFT,  1, 0, 0};
        vec[7]  = '{K_LEFT,  1'b0, D_LEFT,  2, 0, 0};  // judged against tail UP
        vec[8]  = '{K_DOWN,  1'b0, D_LEFT,  2, 1, 0};  // queue full
        vec[9]  = '{K_NONE,  1'b1, D_UP,    1, 0, 1};
        vec[10] = '{K_NONE,  1'b1, D_LEFT,  0, 0, 1};
        vec[11] = '{K_NONE,  1'b1, D_LEFT,  0, 0, 0};  // step with empty queue

        rst_n = 1'b0;
        key_n = K_NONE;
        step  = 1'b0;
        clear = 1'b0;
        e_cnt = 0;
        m_reset();
        repeat (3) @(negedge clk);
        chk("rst_dir", int'(dir), int'(INIT));
        chk("rst_pending", int'(pending), 0);
        chk("rst_dir_changed", int'(dir_changed), 0);
        chk("rst_press_drop", int'(press_drop), 0);
        rst_n = 1'b1;

        // idle after reset
        seen_drop = 0;
        seen_chg  = 0;
        repeat (50) tick(K_NONE, 1'b0, 1'b0);
        chk("idle_pulses", seen_drop + seen_chg, 0);

        // table-driven single presses
        for (int v = 0; v < NV; v++) begin
            seen_drop = 0;
            seen_chg  = 0;
            repeat (10) tick(vec[v].key_n, 1'b0, 1'b0);
            repeat (6) tick(K_NONE, 1'b0, 1'b0);
            if (vec[v].do_step) begin
                tick(K_NONE, 1'b1, 1'b0);
                tick(K_NONE, 1'b0, 1'b0);
            end
            chk($sformatf("vec%0d_dir", v), int'(dir), int'(vec[v].exp_dir));
            chk($sformatf("vec%0d_pending", v), int'(pending), vec[v].exp_pend);
            chk($sformatf("vec%0d_drops", v), seen_drop, vec[v].exp_drops);
            chk($sformatf("vec%0d_changes", v), seen_chg, vec[v].exp_chg);
        end

        // press latency: DOWN from LEFT, pending rises exactly 7 edges after the fall
        seen_drop = 0;
        seen_chg  = 0;
        for (int i = 0; i < 10; i++) begin
            tick(K_DOWN, 1'b0, 1'b0);
            if (i == 6) chk("lat_pending_e6", int'(pending), 0);
            if (i == 7) chk("lat_pending_e7", int'(pending), 1);
        end
        repeat (10) tick(K_NONE, 1'b0, 1'b0);
        tick(K_NONE, 1'b1, 1'b0);
        tick(K_NONE, 1'b0, 1'b0);
        chk("lat_dir", int'(dir), int'(D_DOWN));
        chk("lat_changes", seen_chg, 1);

        // bouncing DOWN never becomes a press
        seen_drop = 0;
        for (int i = 0; i < 20; i++) tick(((i / 2) % 2 == 0) ? K_DOWN : K_NONE, 1'b0, 1'b0);
        repeat (10) tick(K_NONE, 1'b0, 1'b0);
        chk("bounce_pending", int'(pending), 0);
        chk("bounce_drops", seen_drop, 0);

        // UP+RIGHT together while heading DOWN: RIGHT is taken
        seen_drop = 0;
        repeat (10) tick(4'b1010, 1'b0, 1'b0);
        repeat (6) tick(K_NONE, 1'b0, 1'b0);
        chk("simul_pending", int'(pending), 1);
        chk("simul_drops", seen_drop, 0);
        repeat (10) tick(K_UP, 1'b0, 1'b0);
        repeat (6) tick(K_NONE, 1'b0, 1'b0);
        chk("full_pending", int'(pending), 2);
        // step lands on the same edge as the LEFT press into a full queue
        for (int i = 0; i < 10; i++) begin
            tick(K_LEFT, (i == 7), 1'b0);
            if (i == 7) begin
                chk("pushpop_pending", int'(pending), 2);
                chk("pushpop_dir", int'(dir), int'(D_RIGHT));
            end
        end
        repeat (6) tick(K_NONE, 1'b0, 1'b0);
        chk("pushpop_drops", seen_drop, 0);
        tick(K_NONE, 1'b1, 1'b0);
        chk("drain1_dir", int'(dir), int'(D_UP));
        tick(K_NONE, 1'b1, 1'b0);
        chk("drain2_dir", int'(dir), int'(D_LEFT));
        chk("drain2_pending", int'(pending), 0);

        // clear while UP is held: state restarts, UP re-registers
        for (int i = 0; i < 20; i++) begin
            tick(K_UP, 1'b0, (i == 12));
            if (i == 11) chk("clr_pre_pending", int'(pending), 1);
            if (i == 12) begin
                chk("clr_dir", int'(dir), int'(INIT));
                chk("clr_pending", int'(pending), 0);
                chk("clr_pulses", int'(dir_changed) + int'(press_drop), 0);
            end
            if (i == 17) chk("clr_rereg_e17", int'(pending), 0);
            if (i == 18) chk("clr_rereg_e18", int'(pending), 1);
        end
        repeat (6) tick(K_NONE, 1'b0, 1'b0);
        tick(K_NONE, 1'b1, 1'b0);
        chk("clr_after_dir", int'(dir), int'(D_UP));

        // asynchronous reset with a turn queued
        repeat (10) tick(K_LEFT, 1'b0, 1'b0);
        repeat (6) tick(K_NONE, 1'b0, 1'b0);
        chk("arst_pre_pending", int'(pending), 1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_dir", int'(dir), int'(INIT));
        chk("arst_pending", int'(pending), 0);
        @(negedge clk);
        rst_n = 1'b1;
        m_reset();

        // random keys (including bounces), steps and rare clears
        rk = K_NONE;
        for (int k = 0; k < 4; k++) rlen[k] = $urandom_range(1, 20);
        for (int c = 0; c < 1500; c++) begin
            for (int k = 0; k < 4; k++) begin
                if (rlen[k] == 0) begin
                    rk[k]   = ~rk[k];
                    rlen[k] = rk[k] ? $urandom_range(1, 14) : $urandom_range(1, 9);
                end
                rlen[k]--;
            end
            tick(rk, ($urandom_range(0, 2) == 0), ($urandom_range(0, 199) == 0));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
